// File: rtl/mem_wb_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_pipe_reg
// Description : MEM/WB pipeline register with valid/ready flow control, flush
//               and bubble insertion. Define MEM_WB_SKID_EN to add a skid
//               entry, which gives a registered in_ready at full throughput.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wb_pipe_reg #(
    parameter int CTRL_W = 2,
    parameter int DATA_W = 69
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        count
);

    localparam logic [CTRL_W-1:0] c_CTRL_NONE = '0;

    logic              r_main_v;
    logic [CTRL_W-1:0] r_main_c;
    logic [DATA_W-1:0] r_main_d;
    logic [1:0]        r_count;

    logic              w_main_v;
    logic [CTRL_W-1:0] w_main_c;
    logic [DATA_W-1:0] w_main_d;
    logic [1:0]        w_count;
    logic              w_accept;
    logic              w_drain;

`ifdef MEM_WB_SKID_EN
    logic              r_skid_v;
    logic [CTRL_W-1:0] r_skid_c;
    logic [DATA_W-1:0] r_skid_d;
    logic              w_skid_v;
    logic [CTRL_W-1:0] w_skid_c;
    logic [DATA_W-1:0] w_skid_d;

    // Ready depends only on skid occupancy, so out_ready never reaches it.
    assign in_ready = !r_skid_v;
`else
    assign in_ready = !r_main_v || out_ready;
`endif

    assign w_accept = in_valid && in_ready;
    assign w_drain  = r_main_v && out_ready;

    always_comb begin
        w_main_v = r_main_v;
        w_main_c = r_main_c;
        w_main_d = r_main_d;
`ifdef MEM_WB_SKID_EN
        w_skid_v = r_skid_v;
        w_skid_c = r_skid_c;
        w_skid_d = r_skid_d;
`endif
        if (flush) begin
            // Data registers keep their contents; only valids and ctrl clear.
            w_main_v = 1'b0;
            w_main_c = c_CTRL_NONE;
`ifdef MEM_WB_SKID_EN
            w_skid_v = 1'b0;
            w_skid_c = c_CTRL_NONE;
`endif
        end
`ifdef MEM_WB_SKID_EN
        else if (w_drain && r_skid_v) begin
            w_main_v = 1'b1;
            w_main_c = r_skid_c;
            w_main_d = r_skid_d;
            if (w_accept) begin
                w_skid_c = in_ctrl;
                w_skid_d = in_data;
            end else begin
                w_skid_v = 1'b0;
            end
        end
`endif
        else if (w_drain) begin
            if (w_accept) begin
                w_main_c = in_ctrl;
                w_main_d = in_data;
            end else begin
                w_main_v = 1'b0;
            end
        end
        else if (!r_main_v) begin
            if (w_accept) begin
                w_main_v = 1'b1;
                w_main_c = in_ctrl;
                w_main_d = in_data;
            end
        end
`ifdef MEM_WB_SKID_EN
        else if (w_accept) begin
            // Main is stalled with a valid entry: park the new one in skid.
            w_skid_v = 1'b1;
            w_skid_c = in_ctrl;
            w_skid_d = in_data;
        end
`endif
    end

`ifdef MEM_WB_SKID_EN
    assign w_count = {1'b0, w_main_v} + {1'b0, w_skid_v};
`else
    assign w_count = {1'b0, w_main_v};
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_main_v <= 1'b0;
            r_main_c <= c_CTRL_NONE;
            r_main_d <= '0;
            r_count  <= 2'd0;
        end else begin
            r_main_v <= w_main_v;
            r_main_c <= w_main_c;
            r_main_d <= w_main_d;
            r_count  <= w_count;
        end
    end

`ifdef MEM_WB_SKID_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_skid_v <= 1'b0;
            r_skid_c <= c_CTRL_NONE;
            r_skid_d <= '0;
        end else begin
            r_skid_v <= w_skid_v;
            r_skid_c <= w_skid_c;
            r_skid_d <= w_skid_d;
        end
    end
`endif

    // Bubbles present a zero control field so WB never writes on them.
    assign out_valid = r_main_v;
    assign out_ctrl  = r_main_v ? r_main_c : c_CTRL_NONE;
    assign out_data  = r_main_d;
    assign count     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_pipe_reg.sv
`default_nettype none
// Testbench for mem_wb_pipe_reg: FIFO reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_mem_wb_pipe_reg;

    localparam int CW = 2;
    localparam int DW = 69;
`ifdef MEM_WB_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [CW-1:0] in_ctrl = '0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic          out_valid;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [1:0]    count;

    mem_wb_pipe_reg #(.CTRL_W(CW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
        .out_data(out_data), .count(count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: the stage is a FIFO of capacity CAP.
    typedef struct packed { logic [CW-1:0] c; logic [DW-1:0] d; } ent_t;
    ent_t          q[$];
    logic [DW-1:0] last_d;
    logic [DW-1:0] seen[$];
    bit            m_drn, m_acc;

    function automatic bit m_ready();
`ifdef MEM_WB_SKID_EN
        return q.size() < CAP;
`else
        return (q.size() == 0) || out_ready;
`endif
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q.delete();
            last_d = '0;
        end else begin
            m_drn = (q.size() > 0) && out_ready;
            m_acc = in_valid && m_ready();
            if (m_drn) seen.push_back(q[0].d);
            if (flush) begin
                if (q.size() > 0) last_d = q[0].d;
                q.delete();
            end else begin
                if (m_drn) begin
                    last_d = q[0].d;
                    void'(q.pop_front());
                end
                if (m_acc) q.push_back('{c: in_ctrl, d: in_data});
            end
        end
    end

    always @(negedge clk) begin
        chk("model out_valid", out_valid, q.size() > 0);
        chk("model out_ctrl", out_ctrl, (q.size() > 0) ? q[0].c : '0);
        chk("model out_data", out_data, (q.size() > 0) ? q[0].d : last_d);
        chk("model count", count, q.size());
        chk("model in_ready", in_ready, m_ready());
    end

    task automatic step(input bit v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                        input bit ordy, input bit fl);
        in_valid = v; in_ctrl = c; in_data = d; out_ready = ordy; flush = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Asynchronous reset with an entry held at the output
        step(1, 2'b01, 69'h77, 0, 0);
        chk("pre-reset out_valid", out_valid, 1);
        in_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("reset out_valid", out_valid, 0);
        chk("reset out_ctrl", out_ctrl, 0);
        chk("reset out_data", out_data, 0);
        chk("reset count", count, 0);
        chk("reset in_ready", in_ready, 1);
        @(posedge clk);
        #1 rst = 1'b1;

        // Streaming at full throughput
        seen.delete();
        for (int i = 1; i <= 5; i++) begin
            step(1, 2'b01, 69'(i), 1, 0);
            chk("stream out_data", out_data, i);
            chk("stream out_valid", out_valid, 1);
            chk("stream in_ready", in_ready, 1);
        end
        step(0, 2'b00, 69'h0, 1, 0);
        chk("stream drained", seen.size(), 5);
        for (int i = 0; i < 5 && i < seen.size(); i++)
            chk("stream order", seen[i], i + 1);

`ifdef MEM_WB_SKID_EN
        // Single stall fills skid; release drains in order
        seen.delete();
        step(1, 2'b01, 69'hA, 1, 0);
        step(1, 2'b01, 69'hB, 0, 0);
        chk("stall count", count, 2);
        chk("stall in_ready", in_ready, 0);
        chk("stall out_data", out_data, 69'hA);
        step(1, 2'b01, 69'hC, 0, 0);
        step(1, 2'b01, 69'hC, 1, 0);
        chk("stall release in_ready", in_ready, 1);
        step(1, 2'b01, 69'hC, 1, 0);
        step(0, 2'b00, 69'h0, 1, 0);
        chk("stall drained", seen.size(), 3);
        if (seen.size() == 3) begin
            chk("stall order 0", seen[0], 69'hA);
            chk("stall order 1", seen[1], 69'hB);
            chk("stall order 2", seen[2], 69'hC);
        end
`endif

        // Flush with a concurrent accept
        seen.delete();
        step(1, 2'b01, 69'h10, 0, 0);
        step(1, 2'b01, 69'h11, 0, 0);
        chk("pre-flush count", count, CAP);
        step(1, 2'b01, 69'hD, 0, 1);
        chk("flush out_valid", out_valid, 0);
        chk("flush out_ctrl", out_ctrl, 0);
        chk("flush count", count, 0);
        chk("flush in_ready", in_ready, 1);
        chk("flush out_data held", out_data, 69'h10);
        step(0, 2'b00, 69'h0, 1, 0);
        step(0, 2'b00, 69'h0, 1, 0);
        chk("flush nothing emitted", seen.size(), 0);

        // Bubble after a reg_write/mem_to_reg entry
        step(1, 2'b11, 69'h55, 1, 0);
        chk("bubble src ctrl", out_ctrl, 2'b11);
        step(0, 2'b00, 69'h0, 1, 0);
        chk("bubble out_valid", out_valid, 0);
        chk("bubble out_ctrl", out_ctrl, 2'b00);
        chk("bubble out_data", out_data, 69'h55);

`ifndef MEM_WB_SKID_EN
        // Combinational ready path in the no-skid build
        step(1, 2'b01, 69'h66, 0, 0);
        in_valid = 1'b0;
        #1;
        chk("noskid in_ready low", in_ready, 0);
        out_ready = 1'b1;
        #1;
        chk("noskid in_ready comb", in_ready, 1);
        @(posedge clk);
        #1;
`endif

        step(0, 2'b00, 69'h0, 1, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_wb_pipe_reg.md
# mem_wb_pipe_reg

Parametrised MEM/WB pipeline stage register with valid/ready flow control, replacing the free-running stage latch between the memory and write-back stages. Carries a write-back control field and a data payload (ALU result, load data, destination register) from MEM to WB. Adds stall back-pressure, synchronous flush, and bubble insertion. A compile-time skid buffer gives full throughput with a registered `in_ready`.

## Interface
- `CTRL_W`, default 2: control field width; bit 0 = reg_write, bit 1 = mem_to_reg; extra bits are passed through.
- `DATA_W`, default 69: payload width, {alu_result[31:0], data_load[31:0], dst[4:0]}.
- `clk`  input  1  clock; all state changes on the rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `flush`  input  1  synchronous squash of all held entries.
- `in_valid`  input  1  MEM stage presents an entry.
- `in_ready`  output  1  stage can accept an entry this cycle.
- `in_ctrl`  input  CTRL_W  control field.
- `in_data`  input  DATA_W  payload.
- `out_valid`  output  1  WB entry present.
- `out_ready`  input  1  WB consumes the entry this cycle.
- `out_ctrl`  output  CTRL_W  control field; forced to 0 when `out_valid` is 0.
- `out_data`  output  DATA_W  payload.
- `count`  output  2  number of held entries (0..2).

## Operation
- Storage:
  - Main register: `main_v`, `main_c`, `main_d`, which drives the outputs.
  - Skid register: `skid_v`, `skid_c`, `skid_d`.
- Reset (`rst` low, asynchronous): all valid bits, ctrl regs, data regs and `count` go to 0. `out_valid`=0, `out_ctrl`=0, `out_data`=0, `in_ready`=1 while in reset and after release.
- Accept: `in_valid && in_ready`. Drain: `out_valid && out_ready`.
- `in_ready` = !`skid_v`. It is a registered function with no combinational path from `out_ready`.
- Next state when there is no flush:
  - Drain and `skid_v`: main takes the skid entry. If accepting, skid takes the input; otherwise skid empties.
  - Drain, `skid_v`=0: main takes the input if accepting; otherwise `main_v`=0.
  - No drain and `main_v`=0: main takes the input if accepting.
  - No drain and `main_v`=1: skid takes the input if accepting.
- Ordering is strictly FIFO. No entry is duplicated or lost except on flush.
- While `out_valid && !out_ready`, `out_ctrl` and `out_data` are held stable.
- Bubble: when `out_valid`=0, `out_ctrl`=0, so reg_write is deasserted. `out_data` holds its last value.
- Flush has priority over all other activity. On the next edge:
  - Both valid bits and both ctrl regs clear. Data regs are unchanged.
  - Any entry accepted in the flush cycle is discarded.
  - Any drain in the flush cycle still counts as consumed by WB.
- `count` = `main_v` + `skid_v`, registered and updated on the same edge.

## Timing
- Latency: 1 cycle from accept to `out_valid` when the stage is empty.
- Throughput: 1 entry per cycle with `out_ready` held at 1.
- A single stall cycle with continuous input moves one entry into skid, and `in_ready` drops on the following cycle. `in_ready` rises again 1 cycle after the skid drains.
- After flush: `out_valid`=0, `count`=0 and `in_ready`=1 in the next cycle.
- Reset asserted mid-transfer: the outputs clear immediately without waiting for a clock edge.

## Configuration
- `MEM_WB_SKID_EN` defined: skid register present, behaviour as above.
- `MEM_WB_SKID_EN` undefined: no skid register, `skid_v` tied to 0, `count` max 1.
  - `in_ready` = !`main_v` || `out_ready`, which is combinational.
  - Full throughput is kept, but `out_ready` has a combinational path to `in_ready`.
  - Flush and bubble rules are unchanged.

## Test plan
- Reset: drive `rst`=0 asynchronously mid-cycle with `main_v`=1 → `out_valid`, `out_ctrl`, `out_data` and `count` read 0 before the next edge; `in_ready`=1.
- Streaming: `out_ready`=1, inputs with data 0x1..0x5 and ctrl 2'b01 on 5 consecutive cycles → outputs 0x1..0x5 on consecutive cycles, each 1 cycle later; `in_ready` stays 1.
- Stall: stream 0xA, 0xB, 0xC and drop `out_ready` when 0xA is at the output → 0xB is held in skid, `count`=2, `in_ready`=0. After releasing `out_ready`, the output order is 0xA, 0xB, 0xC with no loss (skid build only).
- Flush: `count`=2, assert `flush` together with `in_valid` (data 0xD) → next cycle `out_valid`=0, `out_ctrl`=0, `count`=0, and 0xD never appears.
- Bubble: accept ctrl 2'b11, drain it, then `in_valid`=0 → `out_ctrl`=2'b00 while `out_data` holds the prior payload.
- No-skid build: `out_ready`=0 with `main_v`=1 → `in_ready`=0 in the same cycle; setting `out_ready`=1 → `in_ready`=1 combinationally.
